// File: rtl/acc_seq_pkg.sv
// Shared types for the accumulator sequencer: opcodes, ALU functions, FSM states,
// instruction field positions and the registered control bundle.
package acc_seq_pkg;

    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 5;
    localparam int RSV_BIT = 4;
    localparam int ARG_MSB = 3;
    localparam int ARG_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDL  = 4'h1,
        OP_LDH  = 4'h2,
        OP_GET  = 4'h3,
        OP_PUT  = 4'h4,
        OP_LDM  = 4'h5,
        OP_ADD  = 4'h6,
        OP_SUB  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_SHL  = 4'hB,
        OP_IL_C = 4'hC,
        OP_IL_D = 4'hD,
        OP_IL_E = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_DISPATCH = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_WB   = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    typedef struct packed {
        logic        acc_write_en;
        logic        from_reg;
        logic        from_alu;
        logic        from_imm;
        logic        load_hi;
        logic [3:0]  imm;
        alu_op_e     alu_op;
        logic [3:0]  reg_addr;
        logic        reg_write_en;
        logic        ld_sel;
    } ctrl_t;

    // ALU opcodes are laid out contiguously from ADD, so the function is the offset.
    function automatic alu_op_e alu_of(input logic [3:0] op);
        logic [3:0] d;
        d = op - 4'd6;
        return alu_op_e'(d[2:0]);
    endfunction

endpackage

// File: rtl/acc_seq_if.sv
// Instruction handshake, memory read port and control outputs of the accumulator sequencer.
interface acc_seq_if #(
    parameter int W  = 8,
    parameter int IW = 9
);
    logic          Inst_Valid;
    logic [IW-1:0] Inst_In;
    logic          Inst_Ready;
    logic          Acc_Write_En;
    logic          From_Reg;
    logic          From_ALU;
    logic          From_Imm;
    logic          Load_Hi;
    logic [3:0]    Imm_Out;
    logic [2:0]    ALU_Op;
    logic [3:0]    Reg_Addr;
    logic          Reg_Write_En;
    logic          Ld_Sel;
    logic [W-1:0]  Ld_Data;
    logic          Mem_Req;
    logic          Mem_Ack;
    logic [W-1:0]  Mem_Rdata;
    logic          Busy;
    logic          Halted;
    logic          Error;

    modport master (
        output Inst_Valid, Inst_In, Mem_Ack, Mem_Rdata,
        input  Inst_Ready, Acc_Write_En, From_Reg, From_ALU, From_Imm, Load_Hi, Imm_Out,
               ALU_Op, Reg_Addr, Reg_Write_En, Ld_Sel, Ld_Data, Mem_Req, Busy, Halted, Error
    );

    modport slave (
        input  Inst_Valid, Inst_In, Mem_Ack, Mem_Rdata,
        output Inst_Ready, Acc_Write_En, From_Reg, From_ALU, From_Imm, Load_Hi, Imm_Out,
               ALU_Op, Reg_Addr, Reg_Write_En, Ld_Sel, Ld_Data, Mem_Req, Busy, Halted, Error
    );
endinterface

// File: rtl/acc_seq_decode.sv
// Combinational opcode decode into the control bundle, with flags for the
// sequencing opcodes (LDM, HALT) and the illegal encodings.
module acc_seq_decode
    import acc_seq_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] arg,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       is_ldm,
    output logic       is_halt
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        is_ldm  = 1'b0;
        is_halt = 1'b0;
        case (opcode_e'(opcode))
            OP_LDL, OP_LDH: begin
                ctrl.acc_write_en = 1'b1;
                ctrl.from_imm     = 1'b1;
                ctrl.imm          = arg;
                ctrl.load_hi      = (opcode_e'(opcode) == OP_LDH);
            end
            OP_GET: begin
                ctrl.acc_write_en = 1'b1;
                ctrl.from_reg     = 1'b1;
                ctrl.reg_addr     = arg;
            end
            OP_PUT: begin
                ctrl.reg_write_en = 1'b1;
                ctrl.reg_addr     = arg;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
                ctrl.acc_write_en = 1'b1;
                ctrl.from_alu     = 1'b1;
                ctrl.alu_op       = alu_of(opcode);
                ctrl.reg_addr     = arg;
            end
            OP_LDM:                   is_ldm  = 1'b1;
            OP_HALT:                  is_halt = 1'b1;
            OP_IL_C, OP_IL_D, OP_IL_E: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_sequencer.sv
// Instruction-level controller for the accumulator datapath: accepts instructions,
// issues one-cycle registered control pulses and runs the memory-load sequence.
//
// state       | meaning
// ------------+------------------------------------------------------------
// DISPATCH    | ready; accepts one instruction per cycle
// MEM_WAIT    | Mem_Req high, waiting for Mem_Ack or the timeout
// MEM_WB      | one cycle of load write-back (Acc_Write_En, From_Reg, Ld_Sel)
// HALTED      | absorbing until reset; Error set if entered by a fault
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int W           = 8,
    parameter int IW          = 9,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        Reset,
    acc_seq_if.slave    bus
);

    localparam int            CW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_e         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           err_q, err_nxt;
    ctrl_t          ctrl_q, ctrl_nxt;
    logic [W-1:0]   ld_data_q, ld_data_nxt;

    ctrl_t          dec_ctrl;
    logic           dec_illegal;
    logic           dec_ldm;
    logic           dec_halt;
    logic           unused_rsv;

    assign unused_rsv = bus.Inst_In[RSV_BIT];

    acc_seq_decode u_decode (
        .opcode  (bus.Inst_In[OP_MSB:OP_LSB]),
        .arg     (bus.Inst_In[ARG_MSB:ARG_LSB]),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .is_ldm  (dec_ldm),
        .is_halt (dec_halt)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_DISPATCH;
            cnt       <= '0;
            err_q     <= 1'b0;
            ctrl_q    <= '0;
            ld_data_q <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            err_q     <= err_nxt;
            ctrl_q    <= ctrl_nxt;
            ld_data_q <= ld_data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        err_nxt     = err_q;
        ctrl_nxt    = '0;
        ld_data_nxt = ld_data_q;
        case (state)
            ST_DISPATCH: begin
                if (bus.Inst_Valid) begin
                    if (dec_illegal) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_HALTED;
                    end else if (dec_halt) begin
                        state_nxt = ST_HALTED;
                    end else if (dec_ldm) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_MEM_WAIT;
                    end else begin
                        ctrl_nxt  = dec_ctrl;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // Ack is checked first so it wins over a timeout on the same edge.
                if (bus.Mem_Ack) begin
                    ld_data_nxt           = bus.Mem_Rdata;
                    ctrl_nxt.acc_write_en = 1'b1;
                    ctrl_nxt.from_reg     = 1'b1;
                    ctrl_nxt.ld_sel       = 1'b1;
                    cnt_nxt               = '0;
                    state_nxt             = ST_MEM_WB;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_HALTED;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_MEM_WB: state_nxt = ST_DISPATCH;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_DISPATCH;
        endcase
    end

    // Ready is gated by the reset pin so every output reads 0 while reset is held.
    assign bus.Inst_Ready   = Reset & (state == ST_DISPATCH);
    assign bus.Busy         = (state != ST_DISPATCH);
    assign bus.Halted       = (state == ST_HALTED);
    assign bus.Mem_Req      = (state == ST_MEM_WAIT);
    assign bus.Error        = err_q;
    assign bus.Acc_Write_En = ctrl_q.acc_write_en;
    assign bus.From_Reg     = ctrl_q.from_reg;
    assign bus.From_ALU     = ctrl_q.from_alu;
    assign bus.From_Imm     = ctrl_q.from_imm;
    assign bus.Load_Hi      = ctrl_q.load_hi;
    assign bus.Imm_Out      = ctrl_q.imm;
    assign bus.ALU_Op       = ctrl_q.alu_op;
    assign bus.Reg_Addr     = ctrl_q.reg_addr;
    assign bus.Reg_Write_En = ctrl_q.reg_write_en;
    assign bus.Ld_Sel       = ctrl_q.ld_sel;
    assign bus.Ld_Data      = ld_data_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed self-checking bench for acc_sequencer.
module tb_acc_sequencer;

    logic clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    acc_seq_if #(.W(8), .IW(9)) bus();

    acc_sequencer #(.W(8), .IW(9), .MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] mk(input logic [3:0] op, input logic [3:0] arg);
        return {op, 1'b0, arg};
    endfunction

    task automatic do_reset();
        Reset          = 1'b0;
        bus.Inst_Valid = 1'b0;
        bus.Inst_In    = '0;
        bus.Mem_Ack    = 1'b0;
        bus.Mem_Rdata  = '0;
        @(negedge clk);
        Reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        Reset          = 1'b0;
        bus.Inst_Valid = 1'b0;
        bus.Inst_In    = '0;
        bus.Mem_Ack    = 1'b0;
        bus.Mem_Rdata  = '0;
        #2;
        checks++; if (bus.Inst_Ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b exp 0", bus.Inst_Ready); end
        checks++; if ({bus.Busy, bus.Halted, bus.Error, bus.Mem_Req} !== 4'b0) begin errors++; $display("FAIL rst_status: got %b exp 0000", {bus.Busy, bus.Halted, bus.Error, bus.Mem_Req}); end
        checks++; if ({bus.Acc_Write_En, bus.Reg_Write_En, bus.Ld_Sel, bus.From_Imm, bus.From_ALU, bus.From_Reg} !== 6'b0) begin errors++; $display("FAIL rst_pulses: got nonzero exp 0"); end
        checks++; if (bus.Ld_Data !== 8'h00) begin errors++; $display("FAIL rst_ld_data: got %0h exp 0", bus.Ld_Data); end
        @(negedge clk);
        Reset = 1'b1;
        step();
        checks++; if (bus.Inst_Ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b exp 1", bus.Inst_Ready); end
    endtask

    task automatic test_imm_back_to_back();
        logic [7:0] acc;
        acc = 8'h00;
        bus.Inst_Valid = 1'b1;
        bus.Inst_In    = mk(4'h1, 4'h5);
        step();
        checks++; if ({bus.Acc_Write_En, bus.From_Imm, bus.From_ALU, bus.From_Reg} !== 4'b1100) begin errors++; $display("FAIL ldl_ctrl: got %b exp 1100", {bus.Acc_Write_En, bus.From_Imm, bus.From_ALU, bus.From_Reg}); end
        checks++; if (bus.Imm_Out !== 4'h5) begin errors++; $display("FAIL ldl_imm: got %0h exp 5", bus.Imm_Out); end
        checks++; if (bus.Load_Hi !== 1'b0) begin errors++; $display("FAIL ldl_load_hi: got %0b exp 0", bus.Load_Hi); end
        checks++; if (bus.Inst_Ready !== 1'b1) begin errors++; $display("FAIL ldl_ready: got %0b exp 1", bus.Inst_Ready); end
        if (bus.Acc_Write_En && bus.From_Imm) acc = bus.Load_Hi ? {bus.Imm_Out, acc[3:0]} : {acc[7:4], bus.Imm_Out};
        bus.Inst_In = mk(4'h2, 4'hA) | 9'h010;
        step();
        checks++; if (bus.Imm_Out !== 4'hA) begin errors++; $display("FAIL ldh_imm: got %0h exp a", bus.Imm_Out); end
        checks++; if ({bus.Acc_Write_En, bus.From_Imm, bus.Load_Hi} !== 3'b111) begin errors++; $display("FAIL ldh_ctrl: got %b exp 111", {bus.Acc_Write_En, bus.From_Imm, bus.Load_Hi}); end
        if (bus.Acc_Write_En && bus.From_Imm) acc = bus.Load_Hi ? {bus.Imm_Out, acc[3:0]} : {acc[7:4], bus.Imm_Out};
        checks++; if (acc !== 8'hA5) begin errors++; $display("FAIL acc_model: got %0h exp a5", acc); end
        bus.Inst_Valid = 1'b0;
        step();
        checks++; if ({bus.Acc_Write_En, bus.From_Imm} !== 2'b00) begin errors++; $display("FAIL imm_pulse_end: got %b exp 00", {bus.Acc_Write_En, bus.From_Imm}); end
    endtask

    task automatic test_alu_put();
        bus.Inst_Valid = 1'b1;
        bus.Inst_In    = mk(4'h6, 4'h3);
        step();
        checks++; if (bus.ALU_Op !== 3'd0) begin errors++; $display("FAIL add_op: got %0d exp 0", bus.ALU_Op); end
        checks++; if ({bus.Acc_Write_En, bus.From_ALU, bus.From_Imm, bus.From_Reg} !== 4'b1100) begin errors++; $display("FAIL add_ctrl: got %b exp 1100", {bus.Acc_Write_En, bus.From_ALU, bus.From_Imm, bus.From_Reg}); end
        checks++; if (bus.Reg_Addr !== 4'h3) begin errors++; $display("FAIL add_reg: got %0h exp 3", bus.Reg_Addr); end
        bus.Inst_In = mk(4'h4, 4'h7);
        step();
        checks++; if ({bus.Reg_Write_En, bus.Acc_Write_En, bus.From_ALU} !== 3'b100) begin errors++; $display("FAIL put_ctrl: got %b exp 100", {bus.Reg_Write_En, bus.Acc_Write_En, bus.From_ALU}); end
        checks++; if (bus.Reg_Addr !== 4'h7) begin errors++; $display("FAIL put_reg: got %0h exp 7", bus.Reg_Addr); end
        bus.Inst_In = mk(4'hB, 4'h2);
        step();
        checks++; if (bus.ALU_Op !== 3'd5) begin errors++; $display("FAIL shl_op: got %0d exp 5", bus.ALU_Op); end
        bus.Inst_In = mk(4'h3, 4'h9);
        step();
        checks++; if ({bus.Acc_Write_En, bus.From_Reg, bus.From_ALU, bus.Ld_Sel} !== 4'b1100) begin errors++; $display("FAIL get_ctrl: got %b exp 1100", {bus.Acc_Write_En, bus.From_Reg, bus.From_ALU, bus.Ld_Sel}); end
        checks++; if (bus.Reg_Addr !== 4'h9) begin errors++; $display("FAIL get_reg: got %0h exp 9", bus.Reg_Addr); end
        bus.Inst_In = mk(4'h0, 4'hF);
        step();
        checks++; if ({bus.Acc_Write_En, bus.Reg_Write_En, bus.Busy} !== 3'b000) begin errors++; $display("FAIL nop_ctrl: got %b exp 000", {bus.Acc_Write_En, bus.Reg_Write_En, bus.Busy}); end
        bus.Inst_Valid = 1'b0;
    endtask

    task automatic test_ldm_ack();
        int req_cycles;
        do_reset();
        bus.Mem_Ack   = 1'b1;
        bus.Mem_Rdata = 8'hFF;
        step();
        bus.Mem_Ack = 1'b0;
        checks++; if ({bus.Busy, bus.Ld_Data} !== 9'h000) begin errors++; $display("FAIL stray_ack: got %0h exp 0", {bus.Busy, bus.Ld_Data}); end
        bus.Inst_Valid = 1'b1;
        bus.Inst_In    = mk(4'h5, 4'h0);
        step();
        bus.Inst_Valid = 1'b0;
        req_cycles = 0;
        for (int i = 1; i <= 3; i++) begin
            if (bus.Mem_Req) req_cycles++;
            checks++; if (bus.Inst_Ready !== 1'b0) begin errors++; $display("FAIL ldm_wait_ready: cycle %0d got %0b exp 0", i, bus.Inst_Ready); end
            if (i == 3) begin
                bus.Mem_Ack   = 1'b1;
                bus.Mem_Rdata = 8'h3C;
            end
            step();
        end
        bus.Mem_Ack   = 1'b0;
        bus.Mem_Rdata = 8'h00;
        checks++; if (req_cycles !== 3) begin errors++; $display("FAIL ldm_req_cycles: got %0d exp 3", req_cycles); end
        checks++; if ({bus.Mem_Req, bus.Acc_Write_En, bus.From_Reg, bus.Ld_Sel, bus.Inst_Ready} !== 5'b01110) begin errors++; $display("FAIL ldm_wb_ctrl: got %b exp 01110", {bus.Mem_Req, bus.Acc_Write_En, bus.From_Reg, bus.Ld_Sel, bus.Inst_Ready}); end
        checks++; if (bus.Ld_Data !== 8'h3C) begin errors++; $display("FAIL ldm_ld_data: got %0h exp 3c", bus.Ld_Data); end
        step();
        checks++; if ({bus.Inst_Ready, bus.Acc_Write_En, bus.Ld_Sel, bus.Busy} !== 4'b1000) begin errors++; $display("FAIL ldm_done: got %b exp 1000", {bus.Inst_Ready, bus.Acc_Write_En, bus.Ld_Sel, bus.Busy}); end
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        bus.Inst_Valid = 1'b1;
        bus.Inst_In    = mk(4'h5, 4'h0);
        step();
        bus.Inst_Valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            if (i == 15) begin
                bus.Mem_Ack   = 1'b1;
                bus.Mem_Rdata = 8'hC3;
            end
            step();
        end
        bus.Mem_Ack = 1'b0;
        checks++; if ({bus.Ld_Sel, bus.Error, bus.Halted} !== 3'b100) begin errors++; $display("FAIL ack_wins: got %b exp 100", {bus.Ld_Sel, bus.Error, bus.Halted}); end
        checks++; if (bus.Ld_Data !== 8'hC3) begin errors++; $display("FAIL ack_wins_data: got %0h exp c3", bus.Ld_Data); end
    endtask

    task automatic test_ldm_timeout();
        int n;
        logic wrote;
        do_reset();
        bus.Inst_Valid = 1'b1;
        bus.Inst_In    = mk(4'h5, 4'h0);
        step();
        bus.Inst_In = mk(4'h1, 4'h1);
        n = 0;
        while (bus.Mem_Req && n < 40) begin
            n++;
            step();
        end
        checks++; if (n !== 15) begin errors++; $display("FAIL timeout_cycles: got %0d exp 15", n); end
        checks++; if ({bus.Error, bus.Halted, bus.Mem_Req, bus.Inst_Ready, bus.Busy} !== 5'b11001) begin errors++; $display("FAIL timeout_status: got %b exp 11001", {bus.Error, bus.Halted, bus.Mem_Req, bus.Inst_Ready, bus.Busy}); end
        wrote = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            wrote = wrote | bus.Acc_Write_En | bus.Inst_Ready;
        end
        checks++; if (wrote !== 1'b0) begin errors++; $display("FAIL halted_accepts: got %0b exp 0", wrote); end
        checks++; if ({bus.Halted, bus.Error} !== 2'b11) begin errors++; $display("FAIL halted_sticky: got %b exp 11", {bus.Halted, bus.Error}); end
        bus.Inst_Valid = 1'b0;
    endtask

    task automatic test_illegal_halt();
        logic [3:0] ops [3];
        ops[0] = 4'hC; ops[1] = 4'hD; ops[2] = 4'hE;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            bus.Inst_Valid = 1'b1;
            bus.Inst_In    = mk(ops[k], 4'hF);
            step();
            bus.Inst_Valid = 1'b0;
            checks++; if ({bus.Acc_Write_En, bus.Reg_Write_En, bus.Error, bus.Halted, bus.Inst_Ready} !== 5'b00110) begin errors++; $display("FAIL illegal_%0h: got %b exp 00110", ops[k], {bus.Acc_Write_En, bus.Reg_Write_En, bus.Error, bus.Halted, bus.Inst_Ready}); end
        end
        do_reset();
        bus.Inst_Valid = 1'b1;
        bus.Inst_In    = mk(4'hF, 4'h0);
        step();
        checks++; if ({bus.Halted, bus.Error, bus.Busy, bus.Inst_Ready} !== 4'b1010) begin errors++; $display("FAIL halt_status: got %b exp 1010", {bus.Halted, bus.Error, bus.Busy, bus.Inst_Ready}); end
        bus.Inst_In = mk(4'h1, 4'h7);
        step();
        checks++; if ({bus.Acc_Write_En, bus.Halted} !== 2'b01) begin errors++; $display("FAIL halt_no_accept: got %b exp 01", {bus.Acc_Write_En, bus.Halted}); end
        bus.Inst_Valid = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.Inst_Valid = 1'b1;
        bus.Inst_In    = mk(4'h5, 4'h0);
        step();
        bus.Inst_Valid = 1'b0;
        bus.Mem_Ack    = 1'b1;
        bus.Mem_Rdata  = 8'h5A;
        step();
        bus.Mem_Ack = 1'b0;
        step();
        checks++; if (bus.Ld_Data !== 8'h5A) begin errors++; $display("FAIL mid_setup_data: got %0h exp 5a", bus.Ld_Data); end
        bus.Inst_Valid = 1'b1;
        step();
        bus.Inst_Valid = 1'b0;
        step();
        checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL mid_setup_req: got %0b exp 1", bus.Mem_Req); end
        #2;
        Reset = 1'b0;
        #1;
        checks++; if ({bus.Mem_Req, bus.Busy, bus.Inst_Ready, bus.Halted, bus.Error} !== 5'b0) begin errors++; $display("FAIL mid_reset_status: got %b exp 00000", {bus.Mem_Req, bus.Busy, bus.Inst_Ready, bus.Halted, bus.Error}); end
        checks++; if (bus.Ld_Data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %0h exp 0", bus.Ld_Data); end
        @(negedge clk);
        Reset = 1'b1;
        step();
        checks++; if ({bus.Inst_Ready, bus.Error, bus.Busy} !== 3'b100) begin errors++; $display("FAIL mid_release: got %b exp 100", {bus.Inst_Ready, bus.Error, bus.Busy}); end
    endtask

    initial begin
        test_reset();
        test_imm_back_to_back();
        test_alu_put();
        test_ldm_ack();
        test_ack_at_timeout();
        test_ldm_timeout();
        test_illegal_halt();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
